inert_intf_mc: RTL and testbench



---
 rtl/inert_mc_pkg.sv | 30 +++
 rtl/int_sync_edge.sv | 28 ++
 rtl/inert_intf_mc.sv | 219 +++++++++++++++++++++
 tb/tb_inert_intf_mc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_mc_pkg.sv
// Shared types and helpers for the multi-channel inertial sensor interface.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, sensor init command table, read-command builder, signed clamp.
package inert_mc_pkg;

  typedef enum logic [1:0] {INIT, WAIT, RD, PUB} state_t;

  localparam int NUM_INIT = 4;

  // Entry [0] is issued first.
  localparam logic [NUM_INIT-1:0][15:0] INIT_CMDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

  // Bit 15 marks a register read; the low byte is the dummy data phase.
  function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
    return {1'b1, addr[6:0], 8'h00};
  endfunction

  // Readings beyond +/-lim are treated as spurious. Exactly +/-lim passes.
  function automatic logic signed [15:0] clamp16(input logic signed [15:0] val,
                                                 input logic signed [15:0] lim,
                                                 input logic               sat);
    logic signed [15:0] neg_lim;
    neg_lim = -lim;
    if (val > lim)     return sat ? lim : 16'sd0;
    if (val < neg_lim) return sat ? neg_lim : 16'sd0;
    return val;
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge pulse.
// Latency: o_rise asserts 2-3 clk cycles after i_async rises.
// Backpressure: none; a single 1-cycle pulse per rising edge.
// Ports: clk, rst (async active-high), i_async (raw level), o_rise (1-cycle pulse).
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/inert_intf_mc.sv
// Multi-channel inertial sensor front end: init sequence, then per-INT frame reads over an SPI master.
// Latency: one frame = 2*NUM_CH paced SPI reads, then ch_data/vld one cycle after the last read is paced out.
// Backpressure: SPI handshake via spi_wrt/spi_done plus minimum write spacing; INT edges during a frame queue one pending frame.
// Ports: clk, rst, INT (async), spi_done, spi_rd_data[15:0], clr_err -> spi_wrt, spi_cmd[15:0],
//        ch_data[NUM_CH*16-1:0], vld, ovr (sticky overrun), tmo (sticky watchdog).
module inert_intf_mc
  import inert_mc_pkg::*;
#(
  parameter int                  NUM_CH    = 2,
  parameter logic [NUM_CH*8-1:0] ADDR_LIST = {8'h2C, 8'h22},
  parameter int                  INIT_W    = 16,
  parameter int                  GAP_W     = 10,
  parameter int                  TMO_W     = 20,
  parameter bit                  FAST_SIM  = 1'b1,
  parameter logic [15:0]         CLAMP_LIM = 16'h1F00,
  parameter bit                  CLAMP_SAT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  input  logic                   spi_done,
  input  logic [15:0]            spi_rd_data,
  input  logic                   clr_err,
  output logic                   spi_wrt,
  output logic [15:0]            spi_cmd,
  output logic [NUM_CH*16-1:0]   ch_data,
  output logic                   vld,
  output logic                   ovr,
  output logic                   tmo
);

  localparam int NB = 2 * NUM_CH;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (INIT_W > GAP_W) ? INIT_W : GAP_W;
  localparam int IW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  localparam logic [BW-1:0] LAST      = BW'(NB - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(NUM_INIT - 1);
  localparam logic [TW-1:0] INIT_DONE = TW'((1 << INIT_W) - 1);

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic                 r_busy;
  logic                 r_first;      // long power-up wait only applies before the very first command
  logic [IW-1:0]        r_init_idx;
  logic                 r_init_done;
  logic [BW-1:0]        r_byte;
  logic                 r_pend;
  logic [TMO_W-1:0]     r_wd;
  logic [NB-1:0][7:0]   r_shadow;

  logic                 w_int_rise;
  logic                 w_ready;
  logic                 w_init_go;
  logic                 w_wrt;
  logic [15:0]          w_cmd;
  logic                 w_wd_exp;
  logic                 w_in_frame;
  logic [NUM_CH*16-1:0] w_pub;
  logic                 w_unused;

  assign w_unused = ^spi_rd_data[15:8];

  int_sync_edge u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (INT),
    .o_rise  (w_int_rise)
  );

  // Low byte of channel i/2, high byte sits at the next register address.
  function automatic logic [7:0] byte_addr(input logic [BW-1:0] idx);
    logic [7:0] base;
    base = ADDR_LIST[8*int'(idx >> 1) +: 8];
    return base + {7'd0, idx[0]};
  endfunction

  assign w_ready    = !r_busy && (&r_timer[GAP_W-1:0]);
  assign w_init_go  = r_first ? (r_timer >= INIT_DONE) : w_ready;
  assign w_in_frame = (r_state == RD) || (r_state == PUB);

  always_comb begin
    w_state_nxt = r_state;
    w_wrt       = 1'b0;
    w_cmd       = spi_cmd;
    w_wd_exp    = 1'b0;
    case (r_state)
      INIT: begin
        if (!r_init_done) begin
          if (w_init_go) begin
            w_wrt = 1'b1;
            w_cmd = INIT_CMDS[r_init_idx];
          end
        end else if (w_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_int_rise || r_pend) begin
          w_wrt       = 1'b1;
          w_cmd       = rd_cmd(byte_addr('0));
          w_state_nxt = RD;
        end else if (&r_wd) begin
          w_wd_exp    = 1'b1;
          w_state_nxt = INIT;
        end
      end
      RD: begin
        if (w_ready) begin
          if (r_byte == LAST) begin
            w_state_nxt = PUB;
          end else begin
            w_wrt = 1'b1;
            w_cmd = rd_cmd(byte_addr(BW'(r_byte + 1'b1)));
          end
        end
      end
      PUB:     w_state_nxt = WAIT;
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_pub = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (FAST_SIM)
        w_pub[16*k +: 16] = {r_shadow[2*k+1], r_shadow[2*k]};
      else
        w_pub[16*k +: 16] = clamp16($signed({r_shadow[2*k+1], r_shadow[2*k]}),
                                    $signed(CLAMP_LIM), CLAMP_SAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_first     <= 1'b1;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_byte      <= '0;
      r_pend      <= 1'b0;
      r_wd        <= '0;
      r_shadow    <= '0;
      spi_wrt     <= 1'b0;
      spi_cmd     <= '0;
      ch_data     <= '0;
      vld         <= 1'b0;
      ovr         <= 1'b0;
      tmo         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      spi_wrt <= w_wrt;

      // Park the byte-0 read command on the bus while waiting for INT.
      if (w_wrt)
        spi_cmd <= w_cmd;
      else if (w_state_nxt == WAIT && r_state != WAIT)
        spi_cmd <= rd_cmd(byte_addr('0));

      // Saturating so a long idle never aliases back into a short gap.
      if (w_wrt)
        r_timer <= '0;
      else if (!(&r_timer))
        r_timer <= r_timer + 1'b1;

      if (w_wrt)
        r_busy <= 1'b1;
      else if (spi_done)
        r_busy <= 1'b0;

      if (r_state == INIT && w_wrt) begin
        r_first <= 1'b0;
        if (r_init_idx == INIT_LAST)
          r_init_done <= 1'b1;
        else
          r_init_idx <= r_init_idx + 1'b1;
      end else if (w_wd_exp) begin
        r_init_idx  <= '0;
        r_init_done <= 1'b0;
      end

      if (r_state == WAIT && w_wrt)
        r_byte <= '0;
      else if (r_state == RD && w_wrt)
        r_byte <= r_byte + 1'b1;

      if (r_state == RD && spi_done)
        r_shadow[r_byte] <= spi_rd_data[7:0];

      if (r_state == WAIT && w_wrt)
        r_pend <= 1'b0;
      else if (w_int_rise && w_in_frame)
        r_pend <= 1'b1;

      if (r_state == WAIT && w_state_nxt == WAIT)
        r_wd <= r_wd + 1'b1;
      else
        r_wd <= '0;

      vld <= (r_state == PUB);
      if (r_state == PUB)
        ch_data <= w_pub;

      // Set has priority over clear.
      if (w_int_rise && w_in_frame)
        ovr <= 1'b1;
      else if (clr_err)
        ovr <= 1'b0;

      if (w_wd_exp)
        tmo <= 1'b1;
      else if (clr_err)
        tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inert_intf_mc.sv
// Testbench for inert_intf_mc: behavioural SPI slave, frame scoreboard, table of clamp vectors.
// Three instances share all inputs: clamp bypassed, clamp-to-zero, clamp-saturate.
// Ends with a single summary line.
module tb_inert_intf_mc;

  localparam int NUM_CH = 2;

  typedef struct packed {
    logic [31:0] raw;   // {ch1, ch0}; byte 0 = raw[7:0]
    logic [31:0] c0;    // expected with clamp to zero
    logic [31:0] c1;    // expected with saturation
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, INT, spi_done, clr_err;
  logic [15:0] spi_rd_data;
  logic        spi_wrt, c0_wrt, c1_wrt;
  logic [15:0] spi_cmd, c0_cmd, c1_cmd;
  logic [31:0] ch_data, c0_data, c1_data;
  logic        vld, c0_vld, c1_vld, ovr, c0_ovr, c1_ovr, tmo, c0_tmo, c1_tmo;

  int n_chk = 0, n_err = 0, cyc = 0, vld_cnt = 0, last_vld_cyc = 0, rst_epoch = 0;
  logic [7:0]  rd_q[$];
  logic [15:0] cmd_q[$];
  int          wt_q[$];
  vec_t        sb_q[$];
  vec_t        tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inert_intf_mc #(.NUM_CH(2), .ADDR_LIST({8'h2C, 8'h22}), .INIT_W(6), .GAP_W(4), .TMO_W(10),
                  .FAST_SIM(1'b1)) dut (
    .clk(clk), .rst(rst), .INT(INT), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .clr_err(clr_err), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .ch_data(ch_data),
    .vld(vld), .ovr(ovr), .tmo(tmo));

  inert_intf_mc #(.NUM_CH(2), .ADDR_LIST({8'h2C, 8'h22}), .INIT_W(6), .GAP_W(4), .TMO_W(10),
                  .FAST_SIM(1'b0), .CLAMP_LIM(16'h1F00), .CLAMP_SAT(1'b0)) dut_c0 (
    .clk(clk), .rst(rst), .INT(INT), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .clr_err(clr_err), .spi_wrt(c0_wrt), .spi_cmd(c0_cmd), .ch_data(c0_data),
    .vld(c0_vld), .ovr(c0_ovr), .tmo(c0_tmo));

  inert_intf_mc #(.NUM_CH(2), .ADDR_LIST({8'h2C, 8'h22}), .INIT_W(6), .GAP_W(4), .TMO_W(10),
                  .FAST_SIM(1'b0), .CLAMP_LIM(16'h1F00), .CLAMP_SAT(1'b1)) dut_c1 (
    .clk(clk), .rst(rst), .INT(INT), .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .clr_err(clr_err), .spi_wrt(c1_wrt), .spi_cmd(c1_cmd), .ch_data(c1_data),
    .vld(c1_vld), .ovr(c1_ovr), .tmo(c1_tmo));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // SPI slave: done 4 cycles after the strobe, returns the next queued byte for reads.
  initial begin : spi_model
    logic [15:0] c;
    int          ep;
    spi_done    = 1'b0;
    spi_rd_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (spi_wrt === 1'b1 && rst === 1'b0) begin
        c  = spi_cmd;
        ep = rst_epoch;
        cmd_q.push_back(c);
        wt_q.push_back(cyc);
        repeat (3) begin @(posedge clk); #1; end
        if (c[15] && rd_q.size() > 0) spi_rd_data = {8'hEE, rd_q.pop_front()};
        else                          spi_rd_data = 16'hEE00;
        if (ep == rst_epoch) chk("cmd_hold", 64'(spi_cmd), 64'(c));
        spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
      end
    end
  end

  // Scoreboard: every vld must match the oldest expected frame.
  initial begin : monitor
    vec_t e;
    forever begin
      @(posedge clk); #1;
      if (vld === 1'b1) begin
        vld_cnt++;
        last_vld_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_vld: got ch_data %0h expected no frame", ch_data);
        end else begin
          e = sb_q.pop_front();
          chk("ch_data", 64'(ch_data), 64'(e.raw));
          chk("ch_data_clamp0", 64'(c0_data), 64'(e.c0));
          chk("ch_data_clampsat", 64'(c1_data), 64'(e.c1));
          chk("vld_all", 64'({c0_vld, c1_vld}), 64'(2'b11));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic int_pulse();
    INT = 1'b1; tick(3);
    INT = 1'b0; tick(2);
  endtask

  task automatic push_frame(input vec_t v, input bit expect_vld);
    for (int i = 0; i < 4; i++) rd_q.push_back(v.raw[8*i +: 8]);
    if (expect_vld) sb_q.push_back(v);
  endtask

  task automatic wait_cmds(input int n, input int budget, input string name);
    int b = 0;
    while (cmd_q.size() < n && b < budget) begin tick(1); b++; end
    chk(name, 64'(cmd_q.size() >= n), 64'd1);
  endtask

  task automatic wait_vld(input int target, input string name);
    int b = 0;
    while (vld_cnt < target && b < 400) begin tick(1); b++; end
    chk(name, 64'(vld_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (!(spi_cmd === 16'hA200 && spi_wrt === 1'b0) && b < 400) begin tick(1); b++; end
    chk(name, 64'(spi_cmd), 64'hA200);
  endtask

  task automatic chk_cmd4(input string name, input logic [63:0] exp);
    chk({name, "_count"}, 64'(cmd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk(name, 64'((i < cmd_q.size()) ? cmd_q[i] : 16'hxxxx), 64'(exp[48-16*i +: 16]));
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_wrt"}, 64'(spi_wrt), 64'd0);
    chk({tag, "_cmd"}, 64'(spi_cmd), 64'd0);
    chk({tag, "_data"}, 64'({ch_data, c0_data}), 64'd0);
    chk({tag, "_flags"}, 64'({vld, ovr, tmo}), 64'd0);
  endtask

  localparam logic [63:0] INIT_SEQ = {16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [63:0] RD_SEQ   = {16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  initial begin : watchdog
    #800000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int base, t_tmo, b;
    tbl[0] = '{raw: 32'hABCD_1234, c0: 32'h0000_1234, c1: 32'hE100_1234};
    tbl[1] = '{raw: 32'hE100_1F01, c0: 32'hE100_0000, c1: 32'hE100_1F00};
    tbl[2] = '{raw: 32'h1F00_2000, c0: 32'h1F00_0000, c1: 32'h1F00_1F00};
    tbl[3] = '{raw: 32'hE0FF_E0FF, c0: 32'h0000_0000, c1: 32'hE100_E100};
    tbl[4] = '{raw: 32'hFFFF_5678, c0: 32'hFFFF_0000, c1: 32'hFFFF_1F00};
    tbl[5] = '{raw: 32'h7FFF_8000, c0: 32'h0000_0000, c1: 32'h1F00_E100};
    tbl[6] = '{raw: 32'h1EFF_E101, c0: 32'h1EFF_E101, c1: 32'h1EFF_E101};

    rst = 1'b1; INT = 1'b0; clr_err = 1'b0;
    tick(3);
    chk_rst_outputs("reset");

    // Power-up init: first command after the long wait, the rest paced.
    @(negedge clk); rst = 1'b0; base = cyc;
    wait_cmds(4, 400, "init_cmds_seen");
    chk_cmd4("init_cmd", INIT_SEQ);
    if (wt_q.size() >= 4) begin
      chk_rng("init_first_cycle", wt_q[0] - base, 62, 66);
      for (int i = 1; i < 4; i++) chk_rng("init_gap", wt_q[i] - wt_q[i-1], 15, 24);
    end
    wait_idle("enter_wait");
    cmd_q.delete(); wt_q.delete();

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      base = vld_cnt;
      push_frame(tbl[i], 1'b1);
      int_pulse();
      wait_vld(base + 1, "frame_vld");
      chk_cmd4("rd_cmd", RD_SEQ);
      chk("no_ovr", 64'(ovr), 64'd0);
      cmd_q.delete(); wt_q.delete();
      tick(3);
    end

    // Held-high INT: exactly one frame.
    base = vld_cnt;
    push_frame(tbl[0], 1'b1);
    INT = 1'b1;
    wait_vld(base + 1, "held_first");
    tick(150);
    chk("held_single_frame", 64'(vld_cnt), 64'(base + 1));
    chk("held_cmd_count", 64'(cmd_q.size()), 64'd4);
    INT = 1'b0; tick(5);
    cmd_q.delete(); wt_q.delete();

    // Overrun: two edges during a frame collapse into one pending frame.
    base = vld_cnt;
    push_frame(tbl[1], 1'b1);
    push_frame(tbl[2], 1'b1);
    int_pulse();
    wait_cmds(3, 200, "ovr_byte2");
    int_pulse();
    tick(1);
    int_pulse();
    chk("ovr_set", 64'(ovr), 64'd1);
    b = 0;
    while (vld !== 1'b1 && b < 200) begin tick(1); b++; end
    chk("ovr_first_vld", 64'(vld), 64'd1);
    tick(1);
    chk("pend_start_wrt", 64'(spi_wrt), 64'd1);
    chk("pend_start_cmd", 64'(spi_cmd), 64'hA200);
    wait_vld(base + 2, "ovr_second_vld");
    tick(100);
    chk("ovr_collapse", 64'(vld_cnt), 64'(base + 2));
    chk("ovr_cmd_count", 64'(cmd_q.size()), 64'd8);
    chk("ovr_sticky", 64'(ovr), 64'd1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    chk("ovr_cleared", 64'(ovr), 64'd0);
    cmd_q.delete(); wt_q.delete();

    // Watchdog: clr_err held across the set edge, set must win.
    clr_err = 1'b1;
    b = 0;
    while (tmo !== 1'b1 && b < 1300) begin tick(1); b++; end
    clr_err = 1'b0;
    t_tmo = cyc;
    chk("tmo_set", 64'(tmo), 64'd1);
    chk_rng("tmo_delay", t_tmo - last_vld_cyc, 1020, 1028);
    tick(3);
    chk("tmo_set_wins", 64'(tmo), 64'd1);
    wait_cmds(4, 200, "reinit_cmds_seen");
    chk_cmd4("reinit_cmd", INIT_SEQ);
    if (wt_q.size() >= 1) chk_rng("reinit_no_long_wait", wt_q[0] - t_tmo, 0, 5);
    wait_idle("reinit_wait");
    clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
    chk("tmo_cleared", 64'(tmo), 64'd0);
    cmd_q.delete(); wt_q.delete();
    base = vld_cnt;
    push_frame(tbl[3], 1'b1);
    int_pulse();
    wait_vld(base + 1, "post_reinit_vld");
    cmd_q.delete(); wt_q.delete();
    tick(3);

    // Reset during byte 3 aborts the frame.
    base = vld_cnt;
    push_frame(tbl[4], 1'b0);
    int_pulse();
    wait_cmds(4, 200, "rst_byte3");
    #2; rst = 1'b1; rst_epoch++;
    #1;
    chk_rst_outputs("midrst");
    rd_q.delete();
    tick(3);
    @(negedge clk); rst = 1'b0;
    cmd_q.delete(); wt_q.delete();
    tick(20);
    int_pulse();               // edge during INIT is ignored
    wait_cmds(4, 400, "rst_init_seen");
    chk_cmd4("rst_init_cmd", INIT_SEQ);
    wait_idle("rst_wait");
    tick(20);
    chk("rst_no_frame", 64'(vld_cnt), 64'(base));
    chk("rst_int_init_no_ovr", 64'(ovr), 64'd0);
    chk("rst_data_zero", 64'(ch_data), 64'd0);
    cmd_q.delete(); wt_q.delete();
    push_frame(tbl[5], 1'b1);
    int_pulse();
    wait_vld(base + 1, "rst_new_frame");
    chk_cmd4("rst_rd_cmd", RD_SEQ);
    tick(5);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
